// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: synchronizes the raw RX pin, samples each bit at its centre,
// and presents whole bytes with a one-cycle valid or frame_err strobe.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 1250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din,
   output logic [7:0] data_out,
   output logic       valid,
   output logic       frame_err,
   output logic       busy
);

   localparam int H     = CLKS_PER_BIT / 2;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H - 1);
   localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t           state, state_nxt;
   logic             sync1, din_s;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [2:0]       idx, idx_nxt;
   logic [7:0]       shreg, shreg_nxt;
   logic [7:0]       data_nxt;
   logic             valid_nxt, ferr_nxt;

   // Both flops reset high so a reset always looks like an idle line first.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         din_s <= 1'b1;
      end else begin
         sync1 <= din;
         din_s <= sync1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         idx       <= '0;
         shreg     <= '0;
         data_out  <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         shreg     <= shreg_nxt;
         data_out  <= data_nxt;
         valid     <= valid_nxt;
         frame_err <= ferr_nxt;
         busy      <= (state_nxt != IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt + CNT_W'(1);
      idx_nxt   = idx;
      shreg_nxt = shreg;
      data_nxt  = data_out;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (!din_s) state_nxt = START;
         end
         START: begin
            // A start bit that is gone by mid-bit was a glitch.
            if (cnt == H_LAST) begin
               cnt_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = din_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt        = '0;
               shreg_nxt[idx] = din_s;
               idx_nxt        = idx + 3'd1;
               if (idx == 3'd7) state_nxt = STOP;
            end
         end
         STOP: begin
            // Leaving at mid-stop-bit allows a following start bit with no idle gap.
            if (cnt == BIT_LAST) begin
               cnt_nxt = '0;
               if (din_s) begin
                  data_nxt  = shreg;
                  valid_nxt = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  ferr_nxt  = 1'b1;
                  state_nxt = BREAK;
               end
            end
         end
         BREAK: begin
            cnt_nxt = '0;
            if (din_s) state_nxt = IDLE;
         end
         default: begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Bench for uart_rx_byte: hand-tabled frames and corner sequences, then random
// traffic compared against a waveform-level decoder of the recorded RX pin.
module tb_uart_rx_byte;

   localparam int C    = 16;
   localparam int H    = C / 2;
   localparam int MAXC = 16384;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       din = 1'b1;
   logic [7:0] data_out;
   logic       valid, frame_err, busy;

   uart_rx_byte #(.CLKS_PER_BIT(C)) dut (
      .clk(clk), .rst(rst), .din(din),
      .data_out(data_out), .valid(valid), .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Recorded stimulus, observed outputs and model expectations, per cycle.
   bit         pin  [MAXC];
   bit         rstv [MAXC];
   bit         ov   [MAXC];
   bit         ofe  [MAXC];
   bit         ob   [MAXC];
   logic [7:0] od   [MAXC];
   bit         ev   [MAXC];
   bit         ef   [MAXC];
   bit         eb   [MAXC];
   logic [7:0] ed   [MAXC];

   always @(negedge clk) begin
      if (cyc < MAXC) begin
         ov[cyc]  = (valid === 1'b1);
         ofe[cyc] = (frame_err === 1'b1);
         ob[cyc]  = (busy === 1'b1);
         od[cyc]  = data_out;
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
      end
   endtask

   task automatic drive_cycle(input bit d, input bit r);
      if (cyc >= MAXC - 2) begin
         $display("FAIL cycle budget: got %0d cycles, limit %0d", cyc, MAXC);
         $fatal(1, "cycle budget exceeded");
      end
      din = d;
      rst = r;
      pin[cyc]  = d;
      rstv[cyc] = r;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b1, 1'b0);
   endtask

   // rpos: frame-relative cycle at which rst is pulsed, -1 for none.
   task automatic send_frame(input logic [7:0] b, input bit stop, input int bl, input int rpos);
      int n;
      bit v;
      n = 0;
      for (int slot = 0; slot < 10; slot++) begin
         if (slot == 0)      v = 1'b0;
         else if (slot == 9) v = stop;
         else                v = b[slot-1];
         for (int i = 0; i < bl; i++) begin
            drive_cycle(v, n == rpos);
            n++;
         end
      end
   endtask

   function automatic int count_pulses(input int a, input int b, input bit fe);
      int n;
      n = 0;
      for (int c = a; c <= b; c++) if (fe ? ofe[c] : ov[c]) n++;
      return n;
   endfunction

   function automatic int first_valid(input int a, input int b);
      for (int c = a; c <= b; c++) if (ov[c]) return c;
      return -1;
   endfunction

   typedef struct {
      logic [7:0] data;
      int         bl;
      int         gap;
      logic [7:0] exp_data;
      int         exp_lat;
   } vec_t;
   vec_t tbl [8];

   task automatic apply_vec(input int i, output int pcyc);
      int k, p;
      idle(tbl[i].gap);
      k = cyc;
      send_frame(tbl[i].data, 1'b1, tbl[i].bl, -1);
      p = k + tbl[i].exp_lat;
      check($sformatf("vec%0d valid at +%0d", i, tbl[i].exp_lat), int'(ov[p]), 1);
      check($sformatf("vec%0d data_out", i), int'(od[p]), int'(tbl[i].exp_data));
      check($sformatf("vec%0d valid count", i), count_pulses(k, cyc - 1, 1'b0), 1);
      check($sformatf("vec%0d frame_err count", i), count_pulses(k, cyc - 1, 1'b1), 0);
      pcyc = first_valid(k, cyc - 1);
   endtask

   // Reference decoder: what the receiver sees at edge e is the pin two cycles
   // earlier, forced high for the two edges following a reset.
   function automatic bit seen(input int e);
      int n;
      n = e - 1;
      if (n < 2) return 1'b1;
      if (rstv[n-1] || rstv[n-2]) return 1'b1;
      return pin[n-2];
   endfunction

   function automatic bit rst_edge(input int e);
      return (e >= 1) && rstv[e-1];
   endfunction

   function automatic int first_rst(input int a, input int b);
      for (int e = a; e <= b; e++) if (rst_edge(e)) return e;
      return -1;
   endfunction

   task automatic mark_busy(input int a, input int b);
      for (int c = a; c <= b && c < MAXC; c++) eb[c] = 1'b1;
   endtask

   task automatic run_model(input int last);
      int e, s, stp, r;
      logic [7:0] b;
      for (int c = 0; c < MAXC; c++) begin
         ev[c] = 1'b0; ef[c] = 1'b0; eb[c] = 1'b0; ed[c] = 8'h00;
      end
      e = 1;
      while (e + H + 9 * C <= last) begin
         if (rst_edge(e) || seen(e)) begin
            e++;
            continue;
         end
         s = e;
         r = first_rst(s + 1, s + H);
         if (r >= 0) begin mark_busy(s, r - 1); e = r + 1; continue; end
         if (seen(s + H)) begin mark_busy(s, s + H - 1); e = s + H + 1; continue; end
         stp = s + H + 9 * C;
         r = first_rst(s + H + 1, stp);
         if (r >= 0) begin mark_busy(s, r - 1); e = r + 1; continue; end
         for (int j = 0; j < 8; j++) b[j] = seen(s + H + (j + 1) * C);
         if (seen(stp)) begin
            ev[stp] = 1'b1;
            ed[stp] = b;
            mark_busy(s, stp - 1);
            e = stp + 1;
         end else begin
            ef[stp] = 1'b1;
            e = stp + 1;
            while (e < last && !rst_edge(e) && !seen(e)) e++;
            mark_busy(s, e - 1);
            e++;
         end
      end
   endtask

   task automatic compare_model(input int last);
      logic [7:0] cur;
      cur = 8'h00;
      for (int c = 1; c <= last; c++) begin
         if (rstv[c-1]) cur = 8'h00;
         if (ev[c]) cur = ed[c];
         if (c < 8) continue;
         if (ev[c] || ov[c])
            check($sformatf("model valid c%0d", c), int'(ov[c]), int'(ev[c]));
         if (ef[c] || ofe[c])
            check($sformatf("model frame_err c%0d", c), int'(ofe[c]), int'(ef[c]));
         if (ev[c] || ov[c] || (c % 64) == 0)
            check($sformatf("model data_out c%0d", c), int'(od[c]), int'(cur));
         if (ob[c] != ob[c-1] || eb[c] != eb[c-1])
            check($sformatf("model busy c%0d", c), int'(ob[c]), int'(eb[c]));
         if (ov[c])
            check($sformatf("valid+frame_err c%0d", c), int'(ofe[c]), 0);
      end
   endtask

   initial begin
      int k, bl, gap, rp, glen;
      int pc [8];
      logic [7:0] rb;
      bit sb;

      tbl[0] = '{8'h3A, 16, 20, 8'h3A, 155};
      tbl[1] = '{8'h69, 16, 10, 8'h69, 155};
      tbl[2] = '{8'h3A, 16,  0, 8'h3A, 155};
      tbl[3] = '{8'h00, 16, 10, 8'h00, 155};
      tbl[4] = '{8'hFF, 16,  0, 8'hFF, 155};
      tbl[5] = '{8'hA5, 16,  5, 8'hA5, 155};
      tbl[6] = '{8'hC3, 16,  0, 8'hC3, 155};
      tbl[7] = '{8'h96, 17, 20, 8'h96, 155};

      repeat (4) drive_cycle(1'b1, 1'b1);
      idle(2);
      check("reset data_out", int'(data_out), 0);
      check("reset valid", int'(valid), 0);
      check("reset frame_err", int'(frame_err), 0);
      check("reset busy", int'(busy), 0);

      for (int i = 0; i < 3; i++) apply_vec(i, pc[i]);
      check("back-to-back spacing", pc[2] - pc[1], 160);

      // Bad stop bit followed by a long break.
      k = cyc;
      send_frame(8'h55, 1'b0, 16, -1);
      repeat (200) drive_cycle(1'b0, 1'b0);
      check("break frame_err at +155", int'(ofe[k+155]), 1);
      check("break frame_err count", count_pulses(k, cyc - 1, 1'b1), 1);
      check("break valid count", count_pulses(k, cyc - 1, 1'b0), 0);
      check("break data_out held", int'(od[cyc-1]), 8'h3A);
      check("break busy while low", int'(ob[cyc-1]), 1);

      for (int i = 3; i < 5; i++) apply_vec(i, pc[i]);

      // Three-cycle low glitch.
      idle(10);
      k = cyc;
      repeat (3) drive_cycle(1'b0, 1'b0);
      idle(20);
      check("glitch busy high", int'(ob[k+4]), 1);
      check("glitch busy released", int'(ob[k+11]), 0);
      check("glitch valid count", count_pulses(k, cyc - 1, 1'b0), 0);
      check("glitch frame_err count", count_pulses(k, cyc - 1, 1'b1), 0);
      apply_vec(5, pc[5]);

      // One-cycle reset during data bit 4 of 0x81.
      idle(10);
      k = cyc;
      send_frame(8'h81, 1'b1, 16, 5 * C + 4);
      check("reset mid-frame data_out", int'(od[k+85]), 0);
      check("reset mid-frame busy", int'(ob[k+85]), 0);
      check("reset mid-frame valid count", count_pulses(k, cyc - 1, 1'b0), 0);
      check("reset mid-frame frame_err count", count_pulses(k, cyc - 1, 1'b1), 0);
      idle(250);
      for (int i = 6; i < 8; i++) apply_vec(i, pc[i]);

      // Random traffic: mixed bit lengths, bad stops, glitches and resets.
      for (int i = 0; i < 30; i++) begin
         rb  = 8'($urandom);
         sb  = ($urandom_range(0, 7) != 0);
         bl  = int'($urandom_range(15, 17));
         gap = int'($urandom_range(0, 25));
         rp  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 10 * bl - 1)) : -1;
         if ($urandom_range(0, 5) == 0) begin
            glen = int'($urandom_range(1, 10));
            repeat (glen) drive_cycle(1'b0, 1'b0);
            idle(20);
         end
         idle(gap);
         send_frame(rb, sb, bl, rp);
         if (!sb) repeat (int'($urandom_range(0, 40))) drive_cycle(1'b0, 1'b0);
      end
      idle(300);

      run_model(cyc - 1);
      compare_model(cyc - 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
